// File: rtl/bin2bcd_seq_if.sv
// Start/busy/done conversion handshake plus the binary input and BCD result bus.
interface bin2bcd_seq_if #(
  parameter int unsigned BIN_WIDTH = 14,
  parameter int unsigned DIGITS    = 4
);
  logic                    start_i;
  logic [BIN_WIDTH-1:0]    bin_i;
  logic                    busy_o;
  logic                    done_o;
  logic                    ovf_o;
  logic [DIGITS*4-1:0]     bcd_o;

  // Requester side (counter / ADC front end)
  modport master (
    output start_i, bin_i,
    input  busy_o, done_o, ovf_o, bcd_o
  );

  // Converter side
  modport slave (
    input  start_i, bin_i,
    output busy_o, done_o, ovf_o, bcd_o
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock).
// Result register feeds the 7-segment display driver; units digit in bcd_o[3:0].
// Optional: define BIN2BCD_LZB_EN to blank leading zero digits with 4'hF.
module bin2bcd_seq #(
  parameter int unsigned BIN_WIDTH = 14,
  parameter int unsigned DIGITS    = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  bin2bcd_seq_if.slave  bus
);

  // Largest value representable in DIGITS decimal digits is 10^DIGITS - 1.
  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned r;
    r = 64'd1;
    for (int unsigned i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  localparam int unsigned     BCD_W        = DIGITS * 4;
  localparam int unsigned     CNT_W        = $clog2(BIN_WIDTH + 1);
  localparam int unsigned     CMP_W        = BIN_WIDTH + 1;
  localparam longint unsigned MAX_DEC      = pow10(DIGITS) - 64'd1;
  localparam bit              OVF_POSSIBLE = ((64'd1 << BIN_WIDTH) - 64'd1) > MAX_DEC;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [BIN_WIDTH-1:0] shift_q, shift_d;
  logic [BCD_W-1:0]     scratch_q, scratch_d;
  logic [BCD_W-1:0]     adj_c;
  logic [BCD_W-1:0]     blank_c;
  logic [BCD_W-1:0]     result_c;
  logic [CNT_W-1:0]     cnt_q;
  logic                 ovf_pend_q;
  logic                 ovf_cmp_c;
  logic                 load_c, shift_c, finish_c;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state and datapath control strobes
  always_comb begin
    state_d  = state_q;
    load_c   = 1'b0;
    shift_c  = 1'b0;
    finish_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          load_c  = 1'b1;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        shift_c = 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = S_DONE;
      end
      S_DONE: begin
        finish_c = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Overflow decision taken on the captured value, compared one bit wider
  always_comb begin
    ovf_cmp_c = 1'b0;
    if (OVF_POSSIBLE) ovf_cmp_c = ({1'b0, bus.bin_i} > CMP_W'(MAX_DEC));
  end

  // Add-3 per nibble (no inter-nibble carry) then shift {scratch,shift} left by one
  always_comb begin
    adj_c = scratch_q;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (scratch_q[k*4 +: 4] >= 4'd5) adj_c[k*4 +: 4] = scratch_q[k*4 +: 4] + 4'd3;
    end
    scratch_d = {adj_c[BCD_W-2:0], shift_q[BIN_WIDTH-1]};
    shift_d   = {shift_q[BIN_WIDTH-2:0], 1'b0};
  end

`ifdef BIN2BCD_LZB_EN
  logic lead_c;

  // Replace leading zero digits above the units digit with the blank code
  always_comb begin
    lead_c  = 1'b1;
    blank_c = scratch_q;
    for (int k = int'(DIGITS) - 1; k >= 1; k--) begin
      if (lead_c && (scratch_q[k*4 +: 4] == 4'd0)) blank_c[k*4 +: 4] = 4'hF;
      else                                          lead_c = 1'b0;
    end
  end
`else
  assign blank_c = scratch_q;
`endif

  // Saturate to all nines on overflow, blanking never applies then
  assign result_c = ovf_pend_q ? {DIGITS{4'h9}} : blank_c;

  // Datapath and registered handshake/result outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shift_q     <= '0;
      scratch_q   <= '0;
      cnt_q       <= '0;
      ovf_pend_q  <= 1'b0;
      bus.busy_o  <= 1'b0;
      bus.done_o  <= 1'b0;
      bus.ovf_o   <= 1'b0;
      bus.bcd_o   <= '0;
    end else begin
      bus.busy_o <= (state_q != S_IDLE);
      bus.done_o <= finish_c;
      if (load_c) begin
        shift_q    <= bus.bin_i;
        scratch_q  <= '0;
        cnt_q      <= CNT_W'(BIN_WIDTH);
        ovf_pend_q <= ovf_cmp_c;
      end else if (shift_c) begin
        shift_q   <= shift_d;
        scratch_q <= scratch_d;
        cnt_q     <= cnt_q - CNT_W'(1);
      end
      if (finish_c) begin
        bus.bcd_o <= result_c;
        bus.ovf_o <= ovf_pend_q;
      end
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq (BIN_WIDTH=14, DIGITS=4).
module tb_bin2bcd_seq;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   done_cnt;

  bin2bcd_seq_if #(.BIN_WIDTH(14), .DIGITS(4)) bus ();

  bin2bcd_seq #(.BIN_WIDTH(14), .DIGITS(4)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count cycles in which done_o is high
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) done_cnt <= done_cnt;
    else if (bus.done_o) done_cnt <= done_cnt + 1;
  end

  typedef struct {
    logic [13:0] bin;
    logic [15:0] bcd;
    logic        ovf;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Independent reference: decimal digits by division, then saturation/blanking
  function automatic logic [16:0] ref_model(input int v);
    logic [15:0] r;
    int          d;
    bit          lead;
    if (v > 9999) return {1'b1, 16'h9999};
    d = v;
    for (int k = 0; k < 4; k++) begin
      r[k*4 +: 4] = 4'(d % 10);
      d = d / 10;
    end
`ifdef BIN2BCD_LZB_EN
    lead = 1'b1;
    for (int k = 3; k >= 1; k--) begin
      if (lead && r[k*4 +: 4] == 4'd0) r[k*4 +: 4] = 4'hF;
      else lead = 1'b0;
    end
`else
    lead = 1'b0;
`endif
    return {lead & 1'b0, r};
  endfunction

  // One conversion starting from IDLE; returns result, latency in edges after accept
  task automatic run_conv(input logic [13:0] v, output logic [15:0] bcd, output logic ovf,
                          output int lat, output bit busy_ok);
    bus.bin_i   = v;
    bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    lat     = -1;
    busy_ok = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (bus.busy_o !== 1'b1) busy_ok = 1'b0;
      if (bus.done_o === 1'b1) begin
        lat = k;
        break;
      end
    end
    bcd = bus.bcd_o;
    ovf = bus.ovf_o;
  endtask

  initial begin
    logic [15:0] bcd;
    logic        ovf;
    int          lat;
    bit          busy_ok;
    int          d0;
    bit          stable;
    logic [15:0] prev;
    logic [16:0] exp;

    checks      = 0;
    failures    = 0;
    done_cnt    = 0;
    bus.start_i = 1'b0;
    bus.bin_i   = '0;
    rst_n       = 1'b0;

`ifdef BIN2BCD_LZB_EN
    vecs[0] = '{14'd0,     16'hFFF0, 1'b0};
    vecs[1] = '{14'd7,     16'hFFF7, 1'b0};
    vecs[2] = '{14'd42,    16'hFF42, 1'b0};
    vecs[3] = '{14'd100,   16'hF100, 1'b0};
    vecs[4] = '{14'd1000,  16'h1000, 1'b0};
`else
    vecs[0] = '{14'd0,     16'h0000, 1'b0};
    vecs[1] = '{14'd7,     16'h0007, 1'b0};
    vecs[2] = '{14'd42,    16'h0042, 1'b0};
    vecs[3] = '{14'd100,   16'h0100, 1'b0};
    vecs[4] = '{14'd1000,  16'h1000, 1'b0};
`endif
    vecs[5] = '{14'd1234,  16'h1234, 1'b0};
    vecs[6] = '{14'd9999,  16'h9999, 1'b0};
    vecs[7] = '{14'd10000, 16'h9999, 1'b1};
    vecs[8] = '{14'd16383, 16'h9999, 1'b1};
`ifdef BIN2BCD_LZB_EN
    vecs[9] = '{14'd42,    16'hFF42, 1'b0};
`else
    vecs[9] = '{14'd42,    16'h0042, 1'b0};
`endif

    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(bus.busy_o), 32'd0);
    check("reset_done", 32'(bus.done_o), 32'd0);
    check("reset_ovf",  32'(bus.ovf_o),  32'd0);
    check("reset_bcd",  32'(bus.bcd_o),  32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Leave a nonzero result so reset clearing of bcd_o is observable
    run_conv(14'd321, bcd, ovf, lat, busy_ok);
    check("pre_reset_lat", 32'(lat), 32'd15);
    check("pre_reset_bcd", 32'(bcd), 32'(ref_model(321)));

    // Reset mid-conversion
    bus.bin_i   = 14'd1234;
    bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    d0    = done_cnt;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(bus.busy_o), 32'd0);
    check("midrst_done", 32'(bus.done_o), 32'd0);
    check("midrst_ovf",  32'(bus.ovf_o),  32'd0);
    check("midrst_bcd",  32'(bus.bcd_o),  32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    check("midrst_bcd_after", 32'(bus.bcd_o), 32'd0);

    // Table-driven directed vectors
    for (int i = 0; i < 10; i++) begin
      run_conv(vecs[i].bin, bcd, ovf, lat, busy_ok);
      check($sformatf("vec%0d_bcd", i), 32'(bcd), 32'(vecs[i].bcd));
      check($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vecs[i].ovf));
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'd15);
      check($sformatf("vec%0d_busy", i), 32'(busy_ok), 32'd1);
      @(posedge clk); #1;
      check($sformatf("vec%0d_done_pulse", i), 32'(bus.done_o), 32'd0);
      check($sformatf("vec%0d_idle_busy", i), 32'(bus.busy_o), 32'd0);
    end

    // start_i during a busy conversion is ignored; bin_i changes have no effect
    d0          = done_cnt;
    bus.bin_i   = 14'd321;
    bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    bus.bin_i   = 14'd5000;
    bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    lat = -1;
    for (int k = 6; k <= 40; k++) begin
      @(posedge clk); #1;
      if (bus.done_o === 1'b1) begin
        lat = k;
        break;
      end
    end
    check("ign_lat", 32'(lat), 32'd15);
    check("ign_bcd", 32'(bus.bcd_o), 32'(ref_model(321)));
    repeat (25) @(posedge clk);
    #1;
    check("ign_done_count", 32'(done_cnt - d0), 32'd1);

    // Back-to-back with start_i held high, bin_i stepping 1,2,3
    stable      = 1'b1;
    prev        = bus.bcd_o;
    bus.bin_i   = 14'd1;
    bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.bin_i = 14'd2;
    for (int i = 1; i <= 3; i++) begin
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
        @(posedge clk); #1;
        if (bus.done_o === 1'b1) begin
          lat = k;
          break;
        end
        if (bus.bcd_o !== prev) stable = 1'b0;
      end
      check($sformatf("b2b%0d_lat", i), 32'(lat), 32'd15);
      check($sformatf("b2b%0d_bcd", i), 32'(bus.bcd_o), 32'(ref_model(i)));
      prev = bus.bcd_o;
      if (i == 3) bus.start_i = 1'b0;
      @(posedge clk); #1;
      check($sformatf("b2b%0d_done_pulse", i), 32'(bus.done_o), 32'd0);
      bus.bin_i = 14'(i + 2);
    end
    check("b2b_stable", 32'(stable), 32'd1);
    repeat (20) @(posedge clk);
    #1;
    check("b2b_idle", 32'(bus.busy_o), 32'd0);

    // Sweep across the input range against the reference model
    for (int v = 0; v < 16384; v += 61) begin
      run_conv(14'(v), bcd, ovf, lat, busy_ok);
      exp = ref_model(v);
      check($sformatf("sweep%0d_bcd", v), 32'(bcd), 32'(exp[15:0]));
      check($sformatf("sweep%0d_ovf", v), 32'(ovf), 32'(v > 9999));
      check($sformatf("sweep%0d_lat", v), 32'(lat), 32'd15);
    end
    for (int v = 9998; v <= 10001; v++) begin
      run_conv(14'(v), bcd, ovf, lat, busy_ok);
      exp = ref_model(v);
      check($sformatf("edge%0d_bcd", v), 32'(bcd), 32'(exp[15:0]));
      check($sformatf("edge%0d_ovf", v), 32'(ovf), 32'(v > 9999));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
